// File: rtl/factor_game_ctrl.sv
// Round sequencer for the prime-factorization game: steps through one round,
// divides the question by each confirmed prime and keeps a one-digit score.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | waiting for start, score held
//   S_READY    | countdown before the question is sampled from qin
//   S_QUESTION | question shown for a fixed time
//   S_INPUT    | player picks a prime with next/ok, timeout running
//   S_CHECK    | divides work by p through repeated subtraction
//   S_WRONG    | chosen prime was not a factor
//   S_GOOD     | remaining value reached 1, round won
//   S_OUCH     | no factor was accepted before the timeout
module factor_game_ctrl #(
   parameter int READY_CYC     = 4,
   parameter int QUE_CYC       = 8,
   parameter int INPUT_TIMEOUT = 1000,
   parameter int RESULT_CYC    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       next,
   input  logic       ok,
   input  logic [7:0] qin,
   output logic [3:0] state,
   output logic [3:0] din,
   output logic [3:0] que,
   output logic [7:0] rem,
   output logic [3:0] score
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'b0000,
      S_READY    = 4'b0010,
      S_QUESTION = 4'b0011,
      S_INPUT    = 4'b0100,
      S_CHECK    = 4'b0101,
      S_WRONG    = 4'b0111,
      S_GOOD     = 4'b1000,
      S_OUCH     = 4'b1001
   } state_t;

   // One shared down-counter; each timed state reloads it on entry and
   // leaves when it reaches zero, so a load of N-1 gives N cycles.
   localparam logic [15:0] READY_TC  = 16'(READY_CYC - 1);
   localparam logic [15:0] QUE_TC    = 16'(QUE_CYC - 1);
   localparam logic [15:0] INPUT_TC  = 16'(INPUT_TIMEOUT - 1);
   localparam logic [15:0] RESULT_TC = 16'(RESULT_CYC - 1);

   state_t      st;
   logic [15:0] tmr;
   logic [7:0]  work;
   logic [7:0]  quo;
   logic [3:0]  p;

   function automatic logic [3:0] prime_of(input logic [3:0] idx);
      case (idx)
         4'd1:    prime_of = 4'd2;
         4'd2:    prime_of = 4'd3;
         4'd3:    prime_of = 4'd5;
         default: prime_of = 4'd7;
      endcase
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      sat_inc = (v >= 4'd9) ? 4'd9 : v + 4'd1;
   endfunction

   assign state = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= S_IDLE;
         din   <= 4'd0;
         que   <= 4'd0;
         rem   <= 8'd0;
         score <= 4'd0;
         tmr   <= 16'd0;
         work  <= 8'd0;
         quo   <= 8'd0;
         p     <= 4'd0;
      end else begin
         case (st)
            S_IDLE: begin
               if (start) begin
                  st  <= S_READY;
                  que <= 4'd0;
                  din <= 4'd0;
                  tmr <= READY_TC;
               end
            end
            S_READY: begin
               if (tmr == 16'd0) begin
                  rem <= qin;
                  // Questions below 2 have no prime factors: count again.
                  if (qin >= 8'd2) begin
                     st  <= S_QUESTION;
                     tmr <= QUE_TC;
                  end else begin
                     tmr <= READY_TC;
                  end
               end else begin
                  tmr <= tmr - 16'd1;
               end
            end
            S_QUESTION: begin
               if (tmr == 16'd0) begin
                  st  <= S_INPUT;
                  din <= 4'd0;
                  tmr <= INPUT_TC;
               end else begin
                  tmr <= tmr - 16'd1;
               end
            end
            S_INPUT: begin
               if (ok && din != 4'd0) begin
                  st   <= S_CHECK;
                  p    <= prime_of(din);
                  work <= rem;
                  quo  <= 8'd0;
               end else begin
                  // ok with no prime selected still swallows a coincident next
                  if (next && !ok)
                     din <= (din == 4'd4) ? 4'd1 : din + 4'd1;
                  if (tmr == 16'd0) begin
                     st  <= S_OUCH;
                     tmr <= RESULT_TC;
                  end else begin
                     tmr <= tmr - 16'd1;
                  end
               end
            end
            S_CHECK: begin
               if (work >= {4'd0, p}) begin
                  work <= work - {4'd0, p};
                  quo  <= quo + 8'd1;
               end else if (work == 8'd0) begin
                  rem <= quo;
                  que <= sat_inc(que);
                  if (quo == 8'd1) begin
                     st    <= S_GOOD;
                     score <= sat_inc(score);
                     tmr   <= RESULT_TC;
                  end else begin
                     st  <= S_INPUT;
                     tmr <= INPUT_TC;
                  end
               end else begin
                  st  <= S_WRONG;
                  tmr <= RESULT_TC;
               end
            end
            S_WRONG, S_GOOD, S_OUCH: begin
               if (start) begin
                  st  <= S_READY;
                  que <= 4'd0;
                  din <= 4'd0;
                  tmr <= READY_TC;
               end else if (tmr == 16'd0) begin
                  st <= S_IDLE;
               end else begin
                  tmr <= tmr - 16'd1;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_factor_game_ctrl.sv
// Bench for factor_game_ctrl: a small game model pushes the expected output
// snapshot for every cycle, and each snapshot is popped and compared after the edge.
module tb_factor_game_ctrl;

   localparam int READY_CYC     = 2;
   localparam int QUE_CYC       = 3;
   localparam int INPUT_TIMEOUT = 20;
   localparam int RESULT_CYC    = 4;

   localparam logic [3:0] S_IDLE     = 4'b0000;
   localparam logic [3:0] S_READY    = 4'b0010;
   localparam logic [3:0] S_QUESTION = 4'b0011;
   localparam logic [3:0] S_INPUT    = 4'b0100;
   localparam logic [3:0] S_CHECK    = 4'b0101;
   localparam logic [3:0] S_WRONG    = 4'b0111;
   localparam logic [3:0] S_GOOD     = 4'b1000;
   localparam logic [3:0] S_OUCH     = 4'b1001;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic       next  = 1'b0;
   logic       ok    = 1'b0;
   logic [7:0] qin   = 8'd0;
   logic [3:0] state;
   logic [3:0] din;
   logic [3:0] que;
   logic [7:0] rem;
   logic [3:0] score;

   factor_game_ctrl #(
      .READY_CYC     (READY_CYC),
      .QUE_CYC       (QUE_CYC),
      .INPUT_TIMEOUT (INPUT_TIMEOUT),
      .RESULT_CYC    (RESULT_CYC)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .next  (next),
      .ok    (ok),
      .qin   (qin),
      .state (state),
      .din   (din),
      .que   (que),
      .rem   (rem),
      .score (score)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] st;
      logic [3:0] din;
      logic [3:0] que;
      logic [3:0] score;
      logic [7:0] rem;
   } snap_t;

   snap_t sb[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   // game model
   int m_din   = 0;
   int m_que   = 0;
   int m_rem   = 0;
   int m_score = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int prime_of(input int idx);
      case (idx)
         1:       return 2;
         2:       return 3;
         3:       return 5;
         default: return 7;
      endcase
   endfunction

   function automatic int sat9(input int v);
      return (v >= 9) ? 9 : v + 1;
   endfunction

   task automatic observe();
      snap_t s;
      s = sb.pop_front();
      chk({s.tag, ".state"}, int'(state), int'(s.st));
      chk({s.tag, ".din"},   int'(din),   int'(s.din));
      chk({s.tag, ".que"},   int'(que),   int'(s.que));
      chk({s.tag, ".rem"},   int'(rem),   int'(s.rem));
      chk({s.tag, ".score"}, int'(score), int'(s.score));
   endtask

   // Inputs set by the caller are held for exactly this one edge.
   task automatic step(input logic [3:0] st, input string tag);
      snap_t s;
      s.tag   = tag;
      s.st    = st;
      s.din   = 4'(m_din);
      s.que   = 4'(m_que);
      s.score = 4'(m_score);
      s.rem   = 8'(m_rem);
      sb.push_back(s);
      @(posedge clk);
      #1;
      start = 1'b0;
      next  = 1'b0;
      ok    = 1'b0;
      observe();
   endtask

   task automatic hold(input int n, input logic [3:0] st, input string tag);
      for (int i = 0; i < n; i++) step(st, tag);
   endtask

   task automatic begin_round(input int q, input string tag);
      qin   = 8'(q);
      start = 1'b1;
      m_din = 0;
      m_que = 0;
      step(S_READY, {tag, ".ready"});
      hold(READY_CYC - 1, S_READY, {tag, ".ready"});
      m_rem = q;
      step(S_QUESTION, {tag, ".quest"});
      hold(QUE_CYC - 1, S_QUESTION, {tag, ".quest"});
      step(S_INPUT, {tag, ".input"});
   endtask

   task automatic press(input logic n, input logic o, input string tag);
      int p, q, r;
      next = n;
      ok   = o;
      if (o && m_din != 0) begin
         p = prime_of(m_din);
         q = m_rem / p;
         r = m_rem % p;
         step(S_CHECK, {tag, ".chk"});
         hold(q, S_CHECK, {tag, ".chk"});
         if (r != 0) begin
            step(S_WRONG, {tag, ".wrong"});
         end else begin
            m_rem = q;
            m_que = sat9(m_que);
            if (q == 1) begin
               m_score = sat9(m_score);
               step(S_GOOD, {tag, ".good"});
            end else begin
               step(S_INPUT, {tag, ".back"});
            end
         end
      end else begin
         if (n && !o) m_din = (m_din == 4) ? 1 : m_din + 1;
         step(S_INPUT, tag);
      end
   endtask

   task automatic finish_result(input logic [3:0] st, input string tag);
      hold(RESULT_CYC - 1, st, {tag, ".res"});
      step(S_IDLE, {tag, ".idle"});
   endtask

   task automatic time_out(input string tag);
      hold(INPUT_TIMEOUT - 1, S_INPUT, {tag, ".wait"});
      step(S_OUCH, {tag, ".ouch"});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // reset
      rst = 1'b1;
      step(S_IDLE, "reset");
      step(S_IDLE, "reset2");
      rst = 1'b0;
      step(S_IDLE, "idle");

      // 12 = 2*2*3, won round
      begin_round(12, "t1");
      press(1'b1, 1'b0, "t1.next");
      press(1'b0, 1'b1, "t1.ok2a");
      press(1'b0, 1'b1, "t1.ok2b");
      press(1'b1, 1'b0, "t1.next3");
      press(1'b0, 1'b1, "t1.ok3");
      finish_result(S_GOOD, "t1");

      // 15 is odd: dividing by 2 fails
      begin_round(15, "t2");
      press(1'b1, 1'b0, "t2.next");
      press(1'b0, 1'b1, "t2.ok");
      finish_result(S_WRONG, "t2");

      // no buttons: timeout, then early restart from OUCH
      begin_round(9, "t3");
      time_out("t3");
      step(S_OUCH, "t3.ouch2");
      begin_round(10, "t4");

      // prime index walk and ok/next collisions
      press(1'b1, 1'b1, "t4.oknext0");
      start = 1'b1;
      step(S_INPUT, "t4.start_ign");
      for (int i = 0; i < 7; i++) press(1'b1, 1'b0, "t4.walk");
      press(1'b1, 1'b1, "t4.oknext3");
      time_out("t4");
      finish_result(S_OUCH, "t4");

      // rejected question, then reset in the middle of CHECK
      qin   = 8'd1;
      start = 1'b1;
      m_din = 0;
      m_que = 0;
      step(S_READY, "t5.ready");
      step(S_READY, "t5.ready");
      m_rem = 1;
      step(S_READY, "t5.reject");
      step(S_READY, "t5.reject");
      qin   = 8'd200;
      m_rem = 200;
      step(S_QUESTION, "t5.quest");
      hold(QUE_CYC - 1, S_QUESTION, "t5.quest");
      step(S_INPUT, "t5.input");
      press(1'b1, 1'b0, "t5.next");
      ok = 1'b1;
      step(S_CHECK, "t5.chk1");
      step(S_CHECK, "t5.chk2");
      step(S_CHECK, "t5.chk3");
      rst     = 1'b1;
      m_din   = 0;
      m_que   = 0;
      m_rem   = 0;
      m_score = 0;
      step(S_IDLE, "t5.rst");
      rst = 1'b0;
      step(S_IDLE, "t5.idle");

      // score saturation over ten won rounds
      for (int i = 0; i < 10; i++) begin
         begin_round(2, "t6");
         press(1'b1, 1'b0, "t6.next");
         press(1'b0, 1'b1, "t6.ok");
         finish_result(S_GOOD, "t6");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
